// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl
//   Brute-force knapsack search sequencer. A start latches the item table and
//   the limits, then one subset mask per clock is evaluated (0 .. 2^N_ITEMS-1).
//   The best valid subset (highest value, then lowest weight, then lowest mask)
//   is reported together with a one-cycle done pulse.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           search request / cancel (abort acts in SCAN only)
//   item_values/weights    flat tables, item i at [i*VW +: VW]
//   min_value, max_weight  inclusive validity limits
//   busy, cand_mask        scan in progress / subset evaluated this cycle
//   done, found            completion pulse / a valid subset exists
//   best_mask/value/weight best valid subset and its totals
module knap_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int VW      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_ITEMS*VW-1:0] item_values,
  input  logic [N_ITEMS*VW-1:0] item_weights,
  input  logic [VW-1:0]         min_value,
  input  logic [VW-1:0]         max_weight,
  output logic                  busy,
  output logic [N_ITEMS-1:0]    cand_mask,
  output logic                  done,
  output logic                  found,
  output logic [N_ITEMS-1:0]    best_mask,
  output logic [VW-1:0]         best_value,
  output logic [VW-1:0]         best_weight
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;
  state_t state;

  // latched copy of the table; inputs are not looked at again during SCAN
  logic [N_ITEMS-1:0][VW-1:0] lat_val, lat_wgt;
  logic [VW-1:0]              lat_min, lat_max;

  // per-item contribution of the current candidate
  logic [N_ITEMS-1:0][VW-1:0] sel_val, sel_wgt;

  genvar gi;
  generate
    for (gi = 0; gi < N_ITEMS; gi++) begin : g_item
      assign sel_val[gi] = cand_mask[gi] ? lat_val[gi] : '0;
      assign sel_wgt[gi] = cand_mask[gi] ? lat_wgt[gi] : '0;
    end
  endgenerate

  // totals wrap modulo 2^VW
  logic [VW-1:0] cand_val, cand_wgt;
  always_comb begin
    cand_val = '0;
    cand_wgt = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      cand_val = cand_val + sel_val[i];
      cand_wgt = cand_wgt + sel_wgt[i];
    end
  end

  logic cand_ok, cand_better, last_mask;
  assign cand_ok     = (cand_val >= lat_min) && (cand_wgt <= lat_max);
  // strict compares keep the earlier (lower) mask on a full tie
  assign cand_better = !found || (cand_val > best_value) ||
                       ((cand_val == best_value) && (cand_wgt < best_weight));
  assign last_mask   = &cand_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      cand_mask   <= '0;
      best_mask   <= '0;
      best_value  <= '0;
      best_weight <= '0;
      lat_val     <= '0;
      lat_wgt     <= '0;
      lat_min     <= '0;
      lat_max     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lat_val     <= item_values;
            lat_wgt     <= item_weights;
            lat_min     <= min_value;
            lat_max     <= max_weight;
            found       <= 1'b0;
            best_mask   <= '0;
            best_value  <= '0;
            best_weight <= '0;
            cand_mask   <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            found       <= 1'b0;
            best_mask   <= '0;
            best_value  <= '0;
            best_weight <= '0;
            cand_mask   <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            if (cand_ok && cand_better) begin
              found       <= 1'b1;
              best_mask   <= cand_mask;
              best_value  <= cand_val;
              best_weight <= cand_wgt;
            end
            if (last_mask) begin
              cand_mask <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              cand_mask <= cand_mask + 1'b1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl (N_ITEMS=5, VW=32).
module tb_knap_search_ctrl;

  localparam int N  = 5;
  localparam int VW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, abort;
  logic [N*VW-1:0] item_values, item_weights;
  logic [VW-1:0]   min_value, max_weight;
  logic            busy, done, found;
  logic [N-1:0]    cand_mask, best_mask;
  logic [VW-1:0]   best_value, best_weight;

  knap_search_ctrl #(.N_ITEMS(N), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .item_values(item_values), .item_weights(item_weights),
    .min_value(min_value), .max_weight(max_weight),
    .busy(busy), .cand_mask(cand_mask), .done(done), .found(found),
    .best_mask(best_mask), .best_value(best_value), .best_weight(best_weight)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*VW-1:0] pack5(input int a, b, c, d, e);
    return {e[VW-1:0], d[VW-1:0], c[VW-1:0], b[VW-1:0], a[VW-1:0]};
  endfunction

  // leaves the bench at the falling edge right after the start edge (edge 0)
  task automatic start_search(input logic [N*VW-1:0] v, w, input int mn, mx);
    @(negedge clk);
    item_values  = v;
    item_weights = w;
    min_value    = mn[VW-1:0];
    max_weight   = mx[VW-1:0];
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  // returns the number of edges until done is seen, -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic chk_result(input string tag, input logic f, input logic [N-1:0] m,
                            input int v, input int w);
    chk({tag, ".found"}, found, f);
    chk({tag, ".mask"},  best_mask, m);
    chk({tag, ".value"}, best_value, v);
    chk({tag, ".weight"}, best_weight, w);
  endtask

  logic [N*VW-1:0] t1_v, t1_w, t3_v, t3_w;
  int lat, dc0;

  initial begin
    t1_v = pack5(4, 2, 2, 1, 10);
    t1_w = pack5(12, 1, 2, 1, 4);
    t3_v = pack5(5, 5, 0, 0, 0);
    t3_w = pack5(3, 1, 0, 0, 0);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    item_values = '0; item_weights = '0; min_value = '0; max_weight = '0;
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.cand", cand_mask, '0);
    chk_result("rst", 1'b0, '0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: main search, latency and single done pulse
    start_search(t1_v, t1_w, 15, 16);
    chk("t1.busy", busy, 1'b1);
    chk("t1.cand0", cand_mask, '0);
    repeat (5) @(negedge clk);
    chk("t1.cand5", cand_mask, 5'd5);
    wait_done(lat);
    chk("t1.latency", lat + 5, 32);
    chk("t1.busy_done", busy, 1'b0);
    chk_result("t1", 1'b1, 5'b11110, 15, 8);
    @(negedge clk);
    chk("t1.done_1cyc", done, 1'b0);
    chk("t1.hold_mask", best_mask, 5'b11110);

    // 2: nothing valid, then only the empty set valid
    start_search(t1_v, t1_w, 1, 0);
    wait_done(lat);
    chk("t2a.latency", lat, 32);
    chk_result("t2a", 1'b0, '0, 0, 0);
    start_search(t1_v, t1_w, 0, 0);
    wait_done(lat);
    chk_result("t2b", 1'b1, '0, 0, 0);

    // 3: equal value, lower weight replaces the lower mask
    start_search(t3_v, t3_w, 0, 3);
    wait_done(lat);
    chk_result("t3", 1'b1, 5'b00010, 5, 1);

    // 4: input changes and start during SCAN are ignored
    @(negedge clk);
    dc0 = done_cnt;
    start_search(t1_v, t1_w, 15, 16);
    repeat (10) @(negedge clk);
    item_values = pack5(100, 100, 100, 100, 100);
    min_value   = '0;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    wait_done(lat);
    chk("t4.latency", lat, 21);
    chk_result("t4", 1'b1, 5'b11110, 15, 8);
    repeat (4) @(negedge clk);
    chk("t4.one_done", done_cnt - dc0, 1);
    chk("t4.idle_busy", busy, 1'b0);

    // 5: abort clears results, no done, then a normal search
    dc0 = done_cnt;
    start_search(t3_v, t3_w, 0, 3);
    repeat (7) @(negedge clk);
    chk("t5.found_mid", found, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5.busy", busy, 1'b0);
    chk_result("t5.abort", 1'b0, '0, 0, 0);
    repeat (40) @(negedge clk);
    chk("t5.no_done", done_cnt - dc0, 0);
    start_search(t3_v, t3_w, 0, 3);
    wait_done(lat);
    chk("t5.latency", lat, 32);
    chk_result("t5", 1'b1, 5'b00010, 5, 1);

    // 6: asynchronous reset mid-scan
    start_search(t3_v, t3_w, 0, 3);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.busy", busy, 1'b0);
    chk("t6.cand", cand_mask, '0);
    chk("t6.done", done, 1'b0);
    chk_result("t6.rst", 1'b0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_search(t1_v, t1_w, 15, 16);
    wait_done(lat);
    chk("t6.latency", lat, 32);
    chk_result("t6", 1'b1, 5'b11110, 15, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
